bin2gray_counter: RTL

Registered binary counter that publishes its count in reflected Gray code alongside the binary value. It is the encode side of the team's existing 4-bit Gray-to-binary converter: the converter decodes what this block emits. It is intended as the pointer source for clock-domain-crossing structures, where only one bit may change per step, and as a stimulus source for the Gray decoder. Synchronous load, up/down stepping and a wrap pulse are included.

---
 rtl/bin2gray_counter.sv | 70 +++++++
 1 files changed

// File: rtl/bin2gray_counter.sv
// Up/down binary counter with synchronous load that also publishes a registered
// reflected-Gray copy of its count, plus a one-cycle wrap flag.
module bin2gray_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_reg;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_reg;
    logic             wrap_next;

    always_comb begin
        bin_next  = bin_reg;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (up) begin
                bin_next  = bin_reg + ONE;
                wrap_next = (bin_reg == ALL_ONES);
            end else begin
                bin_next  = bin_reg - ONE;
                wrap_next = (bin_reg == '0);
            end
        end
    end

    // Gray is encoded from the next binary value so both registers update on the same edge.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_encode
        if (gi == WIDTH - 1) begin : g_msb
            assign gray_next[gi] = bin_next[gi];
        end else begin : g_lsb
            assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_reg  <= RST_VAL;
            gray_reg <= RST_GRAY;
            wrap_reg <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bin_q  = bin_reg;
    assign gray_q = gray_reg;
    assign wrap   = wrap_reg;

endmodule
